// File: rtl/l2_controller.sv
// l2_controller: sequencing FSM for the two-way L2 data/tag arrays (tag compare, LRU victim, writeback, allocate, refill).
// Latency: read hit responds 2 cycles after acceptance, write hit 3; a miss adds the memory wait(s) plus REFILL/COMPARE/RESPOND.
// Backpressure: one L1 request at a time, held by L1 until ready_L2_L1; memory waits are unbounded unless L2_CTRL_TIMEOUT_EN is defined.
module l2_controller #(
    parameter int TNUM_2  = 18,
    parameter int INUM_2  = 26 - TNUM_2
`ifdef L2_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              read_L1_L2,
    input  logic              write_L1_L2,
    input  logic [INUM_2-1:0] index_L1_L2,
    input  logic [1:0]        hit,
    input  logic [1:0]        dirty,
    input  logic              ready_M,
    output logic              refill,
    output logic              update,
    output logic              way,
    output logic              tag_write,
    output logic              set_dirty,
    output logic              read_L2_M,
    output logic              write_L2_M,
    output logic              ready_L2_L1,
    output logic              busy
`ifdef L2_CTRL_TIMEOUT_EN
    ,
    output logic              error
`endif
);

    localparam int SETS = 1 << INUM_2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COMPARE   = 3'd1,
        S_UPDATE    = 3'd2,
        S_WRITEBACK = 3'd3,
        S_ALLOCATE  = 3'd4,
        S_REFILL    = 3'd5,
        S_RESPOND   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_is_write;
    logic [INUM_2-1:0] r_index;
    logic              r_victim;
    logic              r_hit_way;
    logic [SETS-1:0]   r_lru;

    logic              w_req;
    logic              w_any_hit;
    logic              w_hit_way;
    logic              w_victim;
    logic              w_tmo;

    // Request decode and way selection; a double hit is resolved to way0.
    assign w_req     = read_L1_L2 | write_L1_L2;
    assign w_any_hit = |hit;
    assign w_hit_way = ~hit[0];
    assign w_victim  = ~r_lru[r_index];

`ifdef L2_CTRL_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_error;
    logic             w_mem_wait;

    assign w_mem_wait = (r_state == S_WRITEBACK) || (r_state == S_ALLOCATE);
    assign w_tmo      = w_mem_wait && !ready_M && (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign error      = r_error;

    // Wait counter restarts on every state entry and only advances while waiting on memory.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_tmo_cnt <= '0;
        end else if (!w_mem_wait || (w_next != r_state)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_error <= 1'b0;
        end else if (w_tmo) begin
            r_error <= 1'b1;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch, hit/victim way capture and per-set LRU maintenance.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_is_write <= 1'b0;
            r_index    <= '0;
            r_victim   <= 1'b0;
            r_hit_way  <= 1'b0;
            r_lru      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_is_write <= write_L1_L2;
                        r_index    <= index_L1_L2;
                    end
                end
                S_COMPARE: begin
                    if (w_any_hit) begin
                        r_hit_way        <= w_hit_way;
                        r_lru[r_index]   <= w_hit_way;
                    end else begin
                        r_victim  <= w_victim;
                        // A timed-out miss responds without a re-lookup; report the victim way then.
                        r_hit_way <= w_victim;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic and registered-state output decode.
    always_comb begin
        w_next      = r_state;
        refill      = 1'b0;
        update      = 1'b0;
        way         = 1'b0;
        tag_write   = 1'b0;
        set_dirty   = 1'b0;
        read_L2_M   = 1'b0;
        write_L2_M  = 1'b0;
        ready_L2_L1 = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_req) begin
                    w_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (w_any_hit) begin
                    w_next = r_is_write ? S_UPDATE : S_RESPOND;
                end else if (dirty[w_victim]) begin
                    w_next = S_WRITEBACK;
                end else begin
                    w_next = S_ALLOCATE;
                end
            end
            S_UPDATE: begin
                update    = 1'b1;
                way       = r_hit_way;
                tag_write = 1'b1;
                set_dirty = 1'b1;
                w_next    = S_RESPOND;
            end
            S_WRITEBACK: begin
                write_L2_M = 1'b1;
                way        = r_victim;
                if (ready_M) begin
                    w_next = S_ALLOCATE;
                end else if (w_tmo) begin
                    w_next = S_RESPOND;
                end
            end
            S_ALLOCATE: begin
                read_L2_M = 1'b1;
                if (ready_M) begin
                    w_next = S_REFILL;
                end else if (w_tmo) begin
                    w_next = S_RESPOND;
                end
            end
            S_REFILL: begin
                refill    = 1'b1;
                way       = r_victim;
                tag_write = 1'b1;
                w_next    = S_COMPARE;
            end
            S_RESPOND: begin
                ready_L2_L1 = 1'b1;
                way         = r_hit_way;
                w_next      = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_l2_controller.sv
// tb_l2_controller: directed and randomized transactions against a timeline model of the L2 sequencer.
// The model keeps its own per-set LRU and emits, per transaction, the expected output bundle and stimulus for every cycle.
// Memory latency is randomized per transaction; requests are held until the response pulse.
module tb_l2_controller;

    logic       clk;
    logic       nrst;
    logic       read_L1_L2;
    logic       write_L1_L2;
    logic [7:0] index_L1_L2;
    logic [1:0] hit;
    logic [1:0] dirty;
    logic       ready_M;
    logic       refill;
    logic       update;
    logic       way;
    logic       tag_write;
    logic       set_dirty;
    logic       read_L2_M;
    logic       write_L2_M;
    logic       ready_L2_L1;
    logic       busy;
`ifdef L2_CTRL_TIMEOUT_EN
    logic       error;
`endif

`ifdef L2_CTRL_TIMEOUT_EN
    l2_controller #(.TNUM_2(18), .TIMEOUT(16)) u_dut (
`else
    l2_controller #(.TNUM_2(18)) u_dut (
`endif
        .clk         (clk),
        .nrst        (nrst),
        .read_L1_L2  (read_L1_L2),
        .write_L1_L2 (write_L1_L2),
        .index_L1_L2 (index_L1_L2),
        .hit         (hit),
        .dirty       (dirty),
        .ready_M     (ready_M),
        .refill      (refill),
        .update      (update),
        .way         (way),
        .tag_write   (tag_write),
        .set_dirty   (set_dirty),
        .read_L2_M   (read_L2_M),
        .write_L2_M  (write_L2_M),
        .ready_L2_L1 (ready_L2_L1)
        ,
        .busy        (busy)
`ifdef L2_CTRL_TIMEOUT_EN
        ,
        .error       (error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed bundle: {refill, update, way, tag_write, set_dirty, read_L2_M, write_L2_M, ready_L2_L1, busy}
    logic [8:0] w_outs;
    assign w_outs = {refill, update, way, tag_write, set_dirty, read_L2_M, write_L2_M, ready_L2_L1, busy};

    int n_cmp = 0;
    int n_err = 0;

    logic [255:0] m_lru;
    logic [8:0]   exp_q[$];
    logic [2:0]   stim_q[$];   // {hit, ready_M} driven during that cycle

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] pk(input logic rf, input logic up, input logic wy, input logic tw,
                                      input logic sd, input logic rd, input logic wr, input logic rdy,
                                      input logic bz);
        return {rf, up, wy, tw, sd, rd, wr, rdy, bz};
    endfunction

    function automatic logic [1:0] onehot(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected cycle-by-cycle behaviour of one transaction, from the first COMPARE to RESPOND.
    task automatic build_txn(input logic is_wr, input logic [7:0] idx, input logic [1:0] h,
                             input logic [1:0] d, input int wb_lat, input int al_lat);
        logic w;
        logic v;
        exp_q.delete();
        stim_q.delete();
        if (h != 2'b00) begin
            w = h[0] ? 1'b0 : 1'b1;
            exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
            stim_q.push_back({h, rnd_bit()});
        end else begin
            v = ~m_lru[idx];
            exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
            stim_q.push_back({h, rnd_bit()});
            if (d[v]) begin
                for (int i = 0; i < wb_lat; i++) begin
                    exp_q.push_back(pk(0, 0, v, 0, 0, 0, 1, 0, 1));
                    stim_q.push_back({h, (i == wb_lat - 1) ? 1'b1 : 1'b0});
                end
            end
            for (int i = 0; i < al_lat; i++) begin
                exp_q.push_back(pk(0, 0, 0, 0, 0, 1, 0, 0, 1));
                stim_q.push_back({h, (i == al_lat - 1) ? 1'b1 : 1'b0});
            end
            exp_q.push_back(pk(1, 0, v, 1, 0, 0, 0, 0, 1));
            stim_q.push_back({h, rnd_bit()});
            exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
            stim_q.push_back({onehot(v), rnd_bit()});
            w = v;
        end
        m_lru[idx] = w;
        if (is_wr) begin
            exp_q.push_back(pk(0, 1, w, 1, 1, 0, 0, 0, 1));
            stim_q.push_back({onehot(w), rnd_bit()});
        end
        exp_q.push_back(pk(0, 0, w, 0, 0, 0, 0, 1, 1));
        stim_q.push_back({onehot(w), rnd_bit()});
    endtask

    // Called at the negedge of an IDLE cycle; returns at the negedge of the IDLE cycle after RESPOND.
    task automatic play(input string name, input logic is_wr, input logic [7:0] idx, input logic [1:0] h,
                        input logic [1:0] d, input logic keep_rd);
        check_val({name, "_idle"}, 32'(w_outs), 32'd0);
        write_L1_L2 = is_wr;
        read_L1_L2  = ~is_wr | keep_rd;
        index_L1_L2 = idx;
        dirty       = d;
        hit         = h;
        ready_M     = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check_val($sformatf("%s_c%0d", name, i + 1), 32'(w_outs), 32'(exp_q[i]));
            check_val($sformatf("%s_memx%0d", name, i + 1), 32'(read_L2_M & write_L2_M), 32'd0);
            {hit, ready_M} = stim_q[i];
            if (i == exp_q.size() - 1) begin
                write_L1_L2 = 1'b0;
                if (!keep_rd) read_L1_L2 = 1'b0;
            end
        end
        @(negedge clk);
        ready_M = 1'b0;
    endtask

    task automatic txn(input string name, input logic is_wr, input logic [7:0] idx, input logic [1:0] h,
                       input logic [1:0] d, input int wb_lat, input int al_lat, input logic keep_rd);
        build_txn(is_wr, idx, h, d, wb_lat, al_lat);
        play(name, is_wr, idx, h, d, keep_rd);
    endtask

    initial begin
        nrst        = 1'b0;
        read_L1_L2  = 1'b0;
        write_L1_L2 = 1'b0;
        index_L1_L2 = '0;
        hit         = '0;
        dirty       = '0;
        ready_M     = 1'b0;
        m_lru       = '0;
        repeat (3) @(negedge clk);
        check_val("reset_outs", 32'(w_outs), 32'd0);
`ifdef L2_CTRL_TIMEOUT_EN
        check_val("reset_error", 32'(error), 32'd0);
`endif
        nrst = 1'b1;
        @(negedge clk);

        // Directed cases.
        txn("rd_hit", 1'b0, 8'h05, 2'b01, 2'b00, 0, 0, 1'b0);
        txn("wr_hit", 1'b1, 8'h10, 2'b10, 2'b00, 0, 0, 1'b0);
        txn("clean_miss", 1'b0, 8'h20, 2'b00, 2'b00, 0, 5, 1'b0);
        txn("dirty_miss", 1'b0, 8'h30, 2'b00, 2'b10, 3, 2, 1'b0);
        txn("lru_way0", 1'b0, 8'h05, 2'b00, 2'b00, 0, 1, 1'b0);
        txn("double_hit", 1'b1, 8'h06, 2'b11, 2'b11, 0, 0, 1'b0);
        txn("both_wr", 1'b1, 8'h40, 2'b01, 2'b00, 0, 0, 1'b1);
        txn("both_rd", 1'b0, 8'h40, 2'b00, 2'b11, 2, 3, 1'b0);

        // Reset during ALLOCATE: outputs drop on the next edge and the LRU is cleared.
        read_L1_L2  = 1'b1;
        index_L1_L2 = 8'h07;
        hit         = 2'b00;
        dirty       = 2'b00;
        repeat (3) @(negedge clk);
        check_val("mid_alloc_rd", 32'(read_L2_M), 32'd1);
        nrst       = 1'b0;
        read_L1_L2 = 1'b0;
        @(negedge clk);
        check_val("mid_reset_outs", 32'(w_outs), 32'd0);
        nrst  = 1'b1;
        m_lru = '0;
        @(negedge clk);
        txn("post_reset_miss", 1'b0, 8'h10, 2'b00, 2'b01, 1, 1, 1'b0);

`ifdef L2_CTRL_TIMEOUT_EN
        // Memory never answers: 16 ALLOCATE cycles, then RESPOND with the sticky error set.
        exp_q.delete();
        stim_q.delete();
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        stim_q.push_back({2'b00, 1'b0});
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(pk(0, 0, 0, 0, 0, 1, 0, 0, 1));
            stim_q.push_back({2'b00, 1'b0});
        end
        exp_q.push_back(pk(0, 0, ~m_lru[8'h09], 0, 0, 0, 0, 1, 1));
        stim_q.push_back({2'b00, 1'b0});
        play("timeout", 1'b0, 8'h09, 2'b00, 2'b00, 1'b0);
        check_val("timeout_error", 32'(error), 32'd1);
        txn("after_timeout", 1'b0, 8'h0A, 2'b01, 2'b00, 0, 0, 1'b0);
        check_val("error_sticky", 32'(error), 32'd1);
`endif

        // Randomized transactions over a small index range so LRU state is reused.
        for (int t = 0; t < 60; t++) begin
            logic       is_wr;
            logic       keep;
            logic [7:0] idx;
            logic [1:0] h;
            logic [1:0] d;
            is_wr = rnd_bit();
            keep  = is_wr && ($urandom_range(0, 4) == 0);
            idx   = 8'($urandom_range(0, 7));
            h     = rnd_bit() ? 2'b00 : 2'($urandom_range(1, 3));
            d     = 2'($urandom_range(0, 3));
            txn($sformatf("rnd%0d", t), is_wr, idx, h, d, $urandom_range(1, 4), $urandom_range(1, 4), keep);
            if (keep) begin
                h = rnd_bit() ? 2'b00 : 2'($urandom_range(1, 3));
                txn($sformatf("rnd%0d_rd", t), 1'b0, idx, h, 2'($urandom_range(0, 3)),
                    $urandom_range(1, 4), $urandom_range(1, 4), 1'b0);
            end else begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
